// File: rtl/mono_ro_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mono_ro_seq
//  Description : Readout sequencer for a token-passing monolithic pixel chip.
//                Freezes the chip when its token is up, issues Read pulses,
//                gates ClkOut while the hit word is shifted in MSB first, and
//                hands each word to a valid/ready consumer.
//  Ports       : CLK        - readout clock, all logic on rising edge
//                RST        - asynchronous active-high reset
//                EN         - readout enable (level)
//                TOKOUT     - chip TokOut, asynchronous to CLK
//                DATA_IN    - chip DataOut, sampled while CLK_OUT_EN is high
//                FREEZE     - chip Freeze pad
//                READ       - chip Read pad
//                CLK_OUT_EN - chip ClkOut gate, high only in shift cycles
//                DATA_OUT   - captured hit word
//                DATA_VALID - DATA_OUT holds an unread word
//                DATA_READY - consumer accepts DATA_OUT
//                BUSY       - sequencer is not idle
//                WORD_CNT   - words captured in current frame (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module mono_ro_seq #(
    parameter int DATA_BITS    = 27,
    parameter int FREEZE_SETUP = 4,
    parameter int READ_WIDTH   = 2,
    parameter int TOK_SETTLE   = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 TOKOUT,
    input  logic                 DATA_IN,
    output logic                 FREEZE,
    output logic                 READ,
    output logic                 CLK_OUT_EN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 BUSY,
    output logic [15:0]          WORD_CNT
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_FREEZE   = 3'd1;
    localparam logic [2:0] c_S_READ     = 3'd2;
    localparam logic [2:0] c_S_SHIFT    = 3'd3;
    localparam logic [2:0] c_S_LOAD     = 3'd4;
    localparam logic [2:0] c_S_SETTLE   = 3'd5;
    localparam logic [2:0] c_S_UNFREEZE = 3'd6;

    // Terminal counts of the timed phases (counter starts at 0 on entry)
    localparam logic [15:0] c_FREEZE_LAST = 16'(FREEZE_SETUP - 1);
    localparam logic [15:0] c_READ_LAST   = 16'(READ_WIDTH - 1);
    localparam logic [15:0] c_SHIFT_LAST  = 16'(DATA_BITS - 1);
    localparam logic [15:0] c_SETTLE_LAST = 16'(TOK_SETTLE - 1);

    logic                 r_tok_meta;
    logic                 r_tok_s;
    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [15:0]          r_cnt;
    logic                 w_load;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_freeze;
    logic                 r_read;
    logic                 r_clk_out_en;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic [15:0]          r_word_cnt;

    // TokOut is asynchronous; only the second flop is used by the FSM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tok_meta <= 1'b0;
            r_tok_s    <= 1'b0;
        end else begin
            r_tok_meta <= TOKOUT;
            r_tok_s    <= r_tok_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. LOAD stalls until the output register is free;
    // a word already in SHIFT always runs to completion so the chip's
    // readout pointer stays consistent.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (EN && r_tok_s) begin
                    w_next_state = c_S_FREEZE;
                end
            end
            c_S_FREEZE: begin
                if (r_cnt == c_FREEZE_LAST) begin
                    w_next_state = c_S_READ;
                end
            end
            c_S_READ: begin
                if (r_cnt == c_READ_LAST) begin
                    w_next_state = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_SHIFT_LAST) begin
                    w_next_state = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (!r_data_valid || DATA_READY) begin
                    w_load       = 1'b1;
                    w_next_state = c_S_SETTLE;
                end
            end
            c_S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_next_state = (r_tok_s && EN) ? c_S_READ : c_S_UNFREEZE;
                end
            end
            c_S_UNFREEZE: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // Phase counter restarts on every state change
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 16'd0;
        end else if (w_next_state != r_state) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Pad outputs are decoded from the next state so they are clean flop
    // outputs aligned with the state they belong to.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_freeze     <= 1'b0;
            r_read       <= 1'b0;
            r_clk_out_en <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_freeze     <= (w_next_state == c_S_FREEZE) || (w_next_state == c_S_READ) ||
                            (w_next_state == c_S_SHIFT)  || (w_next_state == c_S_LOAD) ||
                            (w_next_state == c_S_SETTLE);
            r_read       <= (w_next_state == c_S_READ);
            r_clk_out_en <= (w_next_state == c_S_SHIFT);
            r_busy       <= (w_next_state != c_S_IDLE);
        end
    end

    // First sampled bit ends up at the MSB
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
        end else if (r_state == c_S_SHIFT) begin
            r_shift <= {r_shift[DATA_BITS-2:0], DATA_IN};
        end
    end

    // Output word register: a load in the same cycle as a transfer keeps
    // DATA_VALID high with the new word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data_out   <= r_shift;
            r_data_valid <= 1'b1;
        end else if (r_data_valid && DATA_READY) begin
            r_data_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_word_cnt <= 16'd0;
        end else if ((r_state == c_S_IDLE) && (w_next_state == c_S_FREEZE)) begin
            r_word_cnt <= 16'd0;
        end else if (w_load && (r_word_cnt != 16'hFFFF)) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign FREEZE     = r_freeze;
    assign READ       = r_read;
    assign CLK_OUT_EN = r_clk_out_en;
    assign DATA_OUT   = r_data_out;
    assign DATA_VALID = r_data_valid;
    assign BUSY       = r_busy;
    assign WORD_CNT   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mono_ro_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mono_ro_seq
//  Description : Self-checking bench for mono_ro_seq. A chip model serves
//                queued hit words on each Read pulse and pushes them to a
//                scoreboard; a monitor pops and compares on every transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mono_ro_seq;

    localparam int DATA_BITS = 27;

    logic                 CLK;
    logic                 RST;
    logic                 EN;
    logic                 TOKOUT;
    logic                 DATA_IN;
    logic                 FREEZE;
    logic                 READ;
    logic                 CLK_OUT_EN;
    logic [DATA_BITS-1:0] DATA_OUT;
    logic                 DATA_VALID;
    logic                 DATA_READY;
    logic                 BUSY;
    logic [15:0]          WORD_CNT;

    mono_ro_seq #(
        .DATA_BITS    (DATA_BITS),
        .FREEZE_SETUP (4),
        .READ_WIDTH   (2),
        .TOK_SETTLE   (3)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .TOKOUT     (TOKOUT),
        .DATA_IN    (DATA_IN),
        .FREEZE     (FREEZE),
        .READ       (READ),
        .CLK_OUT_EN (CLK_OUT_EN),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .BUSY       (BUSY),
        .WORD_CNT   (WORD_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_BITS-1:0] chip_q[$];
    logic [DATA_BITS-1:0] sb_q[$];
    logic                 tok_force = 1'b0;

    // monitor statistics
    int read_pulses  = 0;
    int freeze_rises = 0;
    int last_setup   = 0;
    int last_rwidth  = 0;
    int last_shift   = 0;
    int last_vlen    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Chip model: a Read rising edge starts the next word (random when the
    // queue is empty); TokOut stays up while more words are queued.
    initial begin
        logic [DATA_BITS-1:0] chip_word;
        logic                 read_d;
        int                   bit_idx;
        chip_word = '0;
        read_d    = 1'b0;
        bit_idx   = 0;
        DATA_IN   = 1'b0;
        TOKOUT    = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (READ && !read_d) begin
                if (chip_q.size() != 0) begin
                    chip_word = chip_q.pop_front();
                end else begin
                    chip_word = DATA_BITS'($urandom);
                end
                sb_q.push_back(chip_word);
                bit_idx = DATA_BITS - 1;
            end
            read_d = READ;
            TOKOUT = tok_force || (chip_q.size() != 0);
            if (CLK_OUT_EN && bit_idx >= 0) begin
                DATA_IN = chip_word[bit_idx];
                bit_idx--;
            end else begin
                DATA_IN = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on transfer, plus pulse-shape statistics
    initial begin
        logic pf, pr, pc, pv;
        int   setup_cnt, rw_cnt, sh_cnt, v_cnt;
        bit   in_setup;
        logic [DATA_BITS-1:0] exp_word;
        pf = 0; pr = 0; pc = 0; pv = 0;
        setup_cnt = 0; rw_cnt = 0; sh_cnt = 0; v_cnt = 0; in_setup = 0;
        forever begin
            @(negedge CLK);
            if (!RST && DATA_VALID && DATA_READY) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("word", 32'(DATA_OUT), 32'(exp_word));
                end
            end
            if (FREEZE && !pf) begin
                freeze_rises++;
                in_setup  = 1;
                setup_cnt = 0;
            end
            if (in_setup) begin
                if (READ) begin
                    last_setup = setup_cnt;
                    in_setup   = 0;
                end else begin
                    setup_cnt++;
                end
            end
            if (READ && !pr) read_pulses++;
            if (READ) rw_cnt++;
            else if (pr) begin last_rwidth = rw_cnt; rw_cnt = 0; end
            if (CLK_OUT_EN) sh_cnt++;
            else if (pc) begin last_shift = sh_cnt; sh_cnt = 0; end
            if (DATA_VALID) v_cnt++;
            else if (pv) begin last_vlen = v_cnt; v_cnt = 0; end
            pf = FREEZE; pr = READ; pc = CLK_OUT_EN; pv = DATA_VALID;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // which: 0 = FREEZE, 1 = CLK_OUT_EN
    task automatic wait_high(input string tag, input int which, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if ((which == 0 && FREEZE) || (which == 1 && CLK_OUT_EN)) begin
                seen = 1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        tick(1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (!BUSY && !DATA_VALID) begin
                done = 1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
        tick(1);
    endtask

    initial begin
        int rd0, fr0, edges;
        logic [DATA_BITS-1:0] w1;
        RST        = 1'b1;
        EN         = 1'b0;
        DATA_READY = 1'b1;
        tick(3);
        check("reset_ctrl", 32'({FREEZE, READ, CLK_OUT_EN, DATA_VALID, BUSY}), 32'd0);
        check("reset_data", 32'(DATA_OUT), 32'd0);
        check("reset_cnt", 32'(WORD_CNT), 32'd0);
        RST = 1'b0;
        tick(2);

        // single word
        EN  = 1'b1;
        rd0 = read_pulses;
        chip_q.push_back(27'h5A5A5A5);
        wait_high("s1_freeze_to", 0, 50);
        wait_idle("s1_idle_to", 300);
        check("s1_setup", 32'(last_setup), 32'd4);
        check("s1_read_w", 32'(last_rwidth), 32'd2);
        check("s1_shift_len", 32'(last_shift), 32'd27);
        check("s1_valid_len", 32'(last_vlen), 32'd1);
        check("s1_word_cnt", 32'(WORD_CNT), 32'd1);
        check("s1_reads", 32'(read_pulses - rd0), 32'd1);
        check("s1_sb_empty", 32'(sb_q.size()), 32'd0);
        check("s1_unfrozen", 32'(FREEZE), 32'd0);
        tick(5);

        // three words under one freeze
        rd0 = read_pulses;
        fr0 = freeze_rises;
        for (int i = 0; i < 3; i++) chip_q.push_back(DATA_BITS'($urandom));
        wait_high("s2_freeze_to", 0, 50);
        wait_idle("s2_idle_to", 600);
        check("s2_freezes", 32'(freeze_rises - fr0), 32'd1);
        check("s2_reads", 32'(read_pulses - rd0), 32'd3);
        check("s2_word_cnt", 32'(WORD_CNT), 32'd3);
        check("s2_sb_empty", 32'(sb_q.size()), 32'd0);
        tick(5);

        // consumer back-pressure across a two-word frame
        DATA_READY = 1'b0;
        rd0 = read_pulses;
        w1  = 27'h7FF0001;
        chip_q.push_back(w1);
        chip_q.push_back(27'h0123456);
        wait_high("s3_freeze_to", 0, 50);
        tick(170);
        check("s3_freeze", 32'(FREEZE), 32'd1);
        check("s3_clkouten", 32'(CLK_OUT_EN), 32'd0);
        check("s3_busy", 32'(BUSY), 32'd1);
        check("s3_valid", 32'(DATA_VALID), 32'd1);
        check("s3_held_word", 32'(DATA_OUT), 32'(w1));
        check("s3_word_cnt", 32'(WORD_CNT), 32'd1);
        check("s3_reads", 32'(read_pulses - rd0), 32'd2);
        DATA_READY = 1'b1;
        wait_idle("s3_idle_to", 300);
        check("s3_word_cnt_end", 32'(WORD_CNT), 32'd2);
        check("s3_sb_empty", 32'(sb_q.size()), 32'd0);
        tick(5);

        // enable dropped during shift with token still high
        tok_force = 1'b1;
        rd0 = read_pulses;
        wait_high("s4_freeze_to", 0, 50);
        wait_high("s4_shift_to", 1, 50);
        tick(5);
        EN = 1'b0;
        wait_idle("s4_idle_to", 300);
        check("s4_reads", 32'(read_pulses - rd0), 32'd1);
        check("s4_word_cnt", 32'(WORD_CNT), 32'd1);
        check("s4_sb_empty", 32'(sb_q.size()), 32'd0);
        tick(50);
        check("s4_no_restart", 32'({BUSY, FREEZE}), 32'd0);
        check("s4_reads_after", 32'(read_pulses - rd0), 32'd1);
        tok_force = 1'b0;
        tick(5);
        EN = 1'b1;
        tick(5);

        // asynchronous reset during shift
        tok_force = 1'b1;
        wait_high("s5_freeze_to", 0, 50);
        wait_high("s5_shift_to", 1, 50);
        tick(5);
        #3;
        RST = 1'b1;
        #1;
        check("s5_async_ctrl", 32'({FREEZE, READ, CLK_OUT_EN, DATA_VALID, BUSY}), 32'd0);
        check("s5_async_data", 32'(DATA_OUT), 32'd0);
        check("s5_async_cnt", 32'(WORD_CNT), 32'd0);
        sb_q.delete();
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            edges++;
            #1;
            if (FREEZE) break;
        end
        check("s5_freeze_seen", 32'(FREEZE), 32'd1);
        check("s5_sync_latency", 32'(edges >= 3), 32'd1);
        check("s5_fresh_cnt", 32'(WORD_CNT), 32'd0);
        tok_force = 1'b0;
        wait_idle("s5_idle_to", 300);
        check("s5_word_cnt", 32'(WORD_CNT), 32'd1);
        check("s5_sb_empty", 32'(sb_q.size()), 32'd0);
        tick(5);

        // one-cycle token pulse, captured by the synchronizer
        rd0 = read_pulses;
        fr0 = freeze_rises;
        tok_force = 1'b1;
        tick(1);
        tok_force = 1'b0;
        wait_high("s6_freeze_to", 0, 20);
        wait_idle("s6_idle_to", 300);
        check("s6_reads", 32'(read_pulses - rd0), 32'd1);
        check("s6_freezes", 32'(freeze_rises - fr0), 32'd1);
        check("s6_word_cnt", 32'(WORD_CNT), 32'd1);
        check("s6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
